// File: rtl/reduce_1024_16_pkg.sv
// rtl/reduce_1024_16_pkg.sv - shared widths and saturation limits for the 1024->16 reduction tree
package reduce_1024_16_pkg;

  localparam int LANE_W    = 16;
  localparam int LANES     = 64;
  localparam int TREE_L0_W = 18;
  localparam int TREE_L1_W = 20;
  localparam int TREE_L2_W = 22;
  localparam int ACC_W     = 32;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32'sd32768;

  localparam logic [7:0] BEAT_MAX = 8'd255;

endpackage

// File: rtl/reduce_add4.sv
// rtl/reduce_add4.sv - registered 4-input signed adder with valid/last pass-through
module reduce_add4 #(
  parameter int IN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*IN_W-1:0]   data_i,
  input  logic                valid_i,
  input  logic                last_i,
  output logic [IN_W+1:0]     sum_o,
  output logic                valid_o,
  output logic                last_o
);

  logic [IN_W+1:0] sum_d;
  logic [IN_W-1:0] term;

  // Sign-extend each operand by two bits so four of them can never overflow.
  always_comb begin
    sum_d = '0;
    term  = '0;
    for (int k = 0; k < 4; k++) begin
      term  = data_i[k*IN_W +: IN_W];
      sum_d = sum_d + {{2{term[IN_W-1]}}, term};
    end
  end

  // Stage register: sum travels with its valid/last qualifiers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_o   <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else begin
      sum_o   <= sum_d;
      valid_o <= valid_i;
      last_o  <= last_i;
    end
  end

endmodule

// File: rtl/reduce_1024_16.sv
// rtl/reduce_1024_16.sv - 64-lane fan-in reduction with frame accumulator; REDUCE_SAT_EN selects saturating output
module reduce_1024_16
  import reduce_1024_16_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_data_v,
  input  logic                    in_last,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_data_v,
  output logic [LANE_W-1:0]       out_data,
  output logic [7:0]              out_beats
);

  logic                    in_v_q;
  logic                    in_last_q;
  logic [LANES*LANE_W-1:0] in_data_q;

  // Beat capture; a last flag without valid is dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_v_q    <= 1'b0;
      in_last_q <= 1'b0;
      in_data_q <= '0;
    end else begin
      in_v_q    <= in_data_v;
      in_last_q <= in_data_v & in_last;
      in_data_q <= in_data;
    end
  end

  logic [16*TREE_L0_W-1:0] l0_sum;
  logic [15:0]             l0_v;
  logic [15:0]             l0_last;
  logic [4*TREE_L1_W-1:0]  l1_sum;
  logic [3:0]              l1_v;
  logic [3:0]              l1_last;
  logic [TREE_L2_W-1:0]    l2_sum;
  logic                    l2_v;
  logic                    l2_last;

  for (genvar g = 0; g < 16; g++) begin : g_l0
    reduce_add4 #(.IN_W(LANE_W)) u_add (
      .clk     (clk),
      .rst     (rst),
      .data_i  (in_data_q[g*4*LANE_W +: 4*LANE_W]),
      .valid_i (in_v_q),
      .last_i  (in_last_q),
      .sum_o   (l0_sum[g*TREE_L0_W +: TREE_L0_W]),
      .valid_o (l0_v[g]),
      .last_o  (l0_last[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_l1
    reduce_add4 #(.IN_W(TREE_L0_W)) u_add (
      .clk     (clk),
      .rst     (rst),
      .data_i  (l0_sum[g*4*TREE_L0_W +: 4*TREE_L0_W]),
      .valid_i (&l0_v[g*4 +: 4]),
      .last_i  (&l0_last[g*4 +: 4]),
      .sum_o   (l1_sum[g*TREE_L1_W +: TREE_L1_W]),
      .valid_o (l1_v[g]),
      .last_o  (l1_last[g])
    );
  end

  reduce_add4 #(.IN_W(TREE_L1_W)) u_l2 (
    .clk     (clk),
    .rst     (rst),
    .data_i  (l1_sum),
    .valid_i (&l1_v),
    .last_i  (&l1_last),
    .sum_o   (l2_sum),
    .valid_o (l2_v),
    .last_o  (l2_last)
  );

  logic [ACC_W-1:0]  acc_q,      acc_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              start_q,    start_d;
  logic              out_v_q,    out_v_d;
  logic [LANE_W-1:0] out_data_q, out_data_d;
  logic [7:0]        out_beats_q, out_beats_d;
  logic [ACC_W-1:0]  sum_ext;
  logic [ACC_W-1:0]  acc_next;
  logic [7:0]        cnt_next;

  // Frame accumulation: restart on frame-start, report and re-arm on last.
  always_comb begin
    sum_ext     = {{(ACC_W-TREE_L2_W){l2_sum[TREE_L2_W-1]}}, l2_sum};
    acc_next    = start_q ? sum_ext : acc_q + sum_ext;
    cnt_next    = start_q ? 8'd1 :
                  (beat_cnt_q == BEAT_MAX) ? BEAT_MAX : beat_cnt_q + 8'd1;
    acc_d       = acc_q;
    beat_cnt_d  = beat_cnt_q;
    start_d     = start_q;
    out_v_d     = 1'b0;
    out_data_d  = out_data_q;
    out_beats_d = out_beats_q;
    if (l2_v) begin
      acc_d      = acc_next;
      beat_cnt_d = cnt_next;
      start_d    = l2_last;
      if (l2_last) begin
        out_v_d     = 1'b1;
        out_beats_d = cnt_next;
`ifdef REDUCE_SAT_EN
        if ($signed(acc_next) > SAT_MAX) begin
          out_data_d = 16'h7FFF;
        end else if ($signed(acc_next) < SAT_MIN) begin
          out_data_d = 16'h8000;
        end else begin
          out_data_d = acc_next[LANE_W-1:0];
        end
`else
        out_data_d = acc_next[LANE_W-1:0];
`endif
      end
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      beat_cnt_q  <= '0;
      start_q     <= 1'b1;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      beat_cnt_q  <= beat_cnt_d;
      start_q     <= start_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_data_v = out_v_q;
  assign out_data   = out_data_q;
  assign out_beats  = out_beats_q;

endmodule

// File: tb/tb_reduce_1024_16.sv
// tb/tb_reduce_1024_16.sv - self-checking bench for reduce_1024_16 against a frame-sum model
module tb_reduce_1024_16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_data_v;
  logic          in_last;
  logic [1023:0] in_data;
  logic          out_data_v;
  logic [15:0]   out_data;
  logic [7:0]    out_beats;

  reduce_1024_16 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_v  (in_data_v),
    .in_last    (in_last),
    .in_data    (in_data),
    .out_data_v (out_data_v),
    .out_data   (out_data),
    .out_beats  (out_beats)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  int          mon_cyc[$];
  logic [15:0] mon_data[$];
  logic [7:0]  mon_beats[$];

  always @(negedge clk) begin
    if (out_data_v === 1'b1) begin
      mon_cyc.push_back(cyc);
      mon_data.push_back(out_data);
      mon_beats.push_back(out_beats);
    end
  end

  function automatic logic [1023:0] const_word(input logic [15:0] v);
    logic [1023:0] w;
    for (int i = 0; i < 64; i++) w[16*i +: 16] = v;
    return w;
  endfunction

  function automatic logic [1023:0] rand_word();
    logic [1023:0] w;
    for (int i = 0; i < 64; i++) w[16*i +: 16] = 16'($urandom);
    return w;
  endfunction

  function automatic longint word_sum(input logic [1023:0] w);
    longint s = 0;
    logic signed [15:0] l;
    for (int i = 0; i < 64; i++) begin
      l = w[16*i +: 16];
      s += l;
    end
    return s;
  endfunction

  function automatic logic [15:0] model_out(input longint total);
    logic signed [31:0] a;
    a = total[31:0];
`ifdef REDUCE_SAT_EN
    if (a > 32767) return 16'h7FFF;
    if (a < -32768) return 16'h8000;
`endif
    return a[15:0];
  endfunction

  task automatic send_beat(input logic [1023:0] w, input logic last, output int edge_n);
    in_data   = w;
    in_data_v = 1'b1;
    in_last   = last;
    @(posedge clk);
    #1;
    edge_n    = cyc;
    in_data_v = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic idle(input int n, input logic junk_last);
    in_last = junk_last;
    repeat (n) @(posedge clk);
    #1;
    in_last = 1'b0;
  endtask

  task automatic clear_mon();
    mon_cyc.delete();
    mon_data.delete();
    mon_beats.delete();
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int k = 0;
    while (mon_data.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (mon_data.size() != n) begin
      fails++;
      $display("FAIL %s pulse count: got %0d expected %0d", name, mon_data.size(), n);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (out_data_v !== 1'b0) begin
      fails++; $display("FAIL reset out_data_v: got %b expected 0", out_data_v);
    end
    tests++;
    if (out_data !== 16'h0) begin
      fails++; $display("FAIL reset out_data: got %h expected 0000", out_data);
    end
    tests++;
    if (out_beats !== 8'h0) begin
      fails++; $display("FAIL reset out_beats: got %0d expected 0", out_beats);
    end
    rst = 1'b0;
    clear_mon();
    idle(8, 1'b1);
    tests++;
    if (mon_data.size() != 0) begin
      fails++; $display("FAIL reset spurious pulse: got %0d expected 0", mon_data.size());
    end
  endtask

  task automatic test_ones();
    int n;
    clear_mon();
    send_beat(const_word(16'd1), 1'b1, n);
    wait_pulses("ones", 1, 20);
    if (mon_data.size() >= 1) begin
      tests++;
      if (mon_data[0] !== 16'd64) begin
        fails++; $display("FAIL ones data: got %0d expected 64", mon_data[0]);
      end
      tests++;
      if (mon_beats[0] !== 8'd1) begin
        fails++; $display("FAIL ones beats: got %0d expected 1", mon_beats[0]);
      end
      tests++;
      if (mon_cyc[0] != n + 4) begin
        fails++; $display("FAIL ones latency: got edge %0d expected %0d", mon_cyc[0], n + 4);
      end
    end
    tests++;
    if (out_data !== 16'd64 || out_beats !== 8'd1) begin
      fails++; $display("FAIL ones hold: got %0d/%0d expected 64/1", out_data, out_beats);
    end
  endtask

  task automatic test_ramp();
    int n;
    logic [1023:0] w;
    for (int i = 0; i < 64; i++) w[16*i +: 16] = 16'(i);
    clear_mon();
    send_beat(w, 1'b1, n);
    wait_pulses("ramp", 1, 20);
    if (mon_data.size() >= 1) begin
      tests++;
      if (mon_data[0] !== 16'd2016) begin
        fails++; $display("FAIL ramp data: got %0d expected 2016", mon_data[0]);
      end
    end
  endtask

  task automatic test_gaps();
    int n;
    clear_mon();
    send_beat(const_word(16'd100), 1'b0, n);
    idle(2, 1'b1);
    send_beat(const_word(16'd100), 1'b0, n);
    idle(5, 1'b1);
    send_beat(const_word(16'd100), 1'b1, n);
    wait_pulses("gaps", 1, 20);
    if (mon_data.size() >= 1) begin
      tests++;
      if (mon_data[0] !== 16'd19200) begin
        fails++; $display("FAIL gaps data: got %0d expected 19200", mon_data[0]);
      end
      tests++;
      if (mon_beats[0] !== 8'd3) begin
        fails++; $display("FAIL gaps beats: got %0d expected 3", mon_beats[0]);
      end
    end
  endtask

  task automatic test_extremes();
    int n;
    logic [15:0] exp_pos, exp_neg;
`ifdef REDUCE_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'hFFC0;
    exp_neg = 16'h0000;
`endif
    clear_mon();
    send_beat(const_word(16'h7FFF), 1'b1, n);
    send_beat(const_word(16'h8000), 1'b1, n);
    wait_pulses("extremes", 2, 20);
    if (mon_data.size() >= 2) begin
      tests++;
      if (mon_data[0] !== exp_pos) begin
        fails++; $display("FAIL max lanes: got %h expected %h", mon_data[0], exp_pos);
      end
      tests++;
      if (mon_data[1] !== exp_neg) begin
        fails++; $display("FAIL min lanes: got %h expected %h", mon_data[1], exp_neg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mon();
    send_beat(const_word(16'd5), 1'b0, n);
    send_beat(const_word(16'd5), 1'b0, n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(const_word(16'd1), 1'b1, n);
    wait_pulses("reset_mid", 1, 20);
    if (mon_data.size() >= 1) begin
      tests++;
      if (mon_data[0] !== 16'd64 || mon_beats[0] !== 8'd1) begin
        fails++; $display("FAIL reset_mid result: got %0d/%0d expected 64/1", mon_data[0], mon_beats[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    clear_mon();
    send_beat(const_word(16'd2), 1'b1, n1);
    send_beat(const_word(16'd3), 1'b1, n2);
    wait_pulses("b2b", 2, 20);
    if (mon_data.size() >= 2) begin
      tests++;
      if (mon_data[0] !== 16'd128 || mon_data[1] !== 16'd192) begin
        fails++; $display("FAIL b2b data: got %0d,%0d expected 128,192", mon_data[0], mon_data[1]);
      end
      tests++;
      if (mon_cyc[0] != n1 + 4 || mon_cyc[1] != n2 + 4 || n2 != n1 + 1) begin
        fails++; $display("FAIL b2b timing: got %0d,%0d expected %0d,%0d", mon_cyc[0], mon_cyc[1], n1 + 4, n1 + 5);
      end
    end
  endtask

  task automatic test_random();
    int n, len;
    longint total;
    logic [15:0] exp_d[$];
    logic [7:0]  exp_b[$];
    logic [1023:0] w;
    clear_mon();
    for (int f = 0; f < 20; f++) begin
      len   = $urandom_range(1, 4);
      total = 0;
      for (int b = 0; b < len; b++) begin
        w = rand_word();
        total += word_sum(w);
        send_beat(w, b == len - 1, n);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3), 1'($urandom));
      end
      exp_d.push_back(model_out(total));
      exp_b.push_back(8'(len));
    end
    wait_pulses("random", 20, 40);
    for (int i = 0; i < 20 && i < mon_data.size(); i++) begin
      tests++;
      if (mon_data[i] !== exp_d[i] || mon_beats[i] !== exp_b[i]) begin
        fails++;
        $display("FAIL random frame %0d: got %h/%0d expected %h/%0d", i, mon_data[i], mon_beats[i], exp_d[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_long_frame();
    int n;
    longint total = 0;
    logic [1023:0] w;
    clear_mon();
    for (int b = 0; b < 300; b++) begin
      w = rand_word();
      total += word_sum(w);
      send_beat(w, b == 299, n);
    end
    wait_pulses("long", 1, 20);
    if (mon_data.size() >= 1) begin
      tests++;
      if (mon_beats[0] !== 8'd255) begin
        fails++; $display("FAIL long beats: got %0d expected 255", mon_beats[0]);
      end
      tests++;
      if (mon_data[0] !== model_out(total)) begin
        fails++; $display("FAIL long data: got %h expected %h", mon_data[0], model_out(total));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data_v = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_ones();
    test_ramp();
    test_gaps();
    test_extremes();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_long_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
